// File: rtl/ntt_pointwise_mul.sv
// Pointwise modular multiply of two latched NTT-domain vectors.
// Accepts an a/b vector pair through a valid/ready handshake, then streams
// (a[i]*b[i]) mod Q for i = 0..N-1 with valid/ready backpressure.
// Each element takes three cycles: MUL, RED, then OUT until accepted.
// Optional range check on accepted coefficients: define NTT_PW_RANGE_CHECK_EN.
module ntt_pointwise_mul #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 8,
  parameter int unsigned Q = 17,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N-1:0][W-1:0] a,
  input  logic [N-1:0][W-1:0] b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        out_data,
  output logic [IW-1:0]       out_idx,
  output logic                out_last,
  output logic                busy,
  output logic                err
);

  localparam logic [IW-1:0]  LastIdx = IW'(N - 1);
  localparam logic [2*W-1:0] QProd   = (2*W)'(Q);

  typedef enum logic [1:0] {StIdle, StMul, StRed, StOut} state_t;

  state_t              state_q;
  logic [N-1:0][W-1:0] a_q;
  logic [N-1:0][W-1:0] b_q;
  logic [IW-1:0]       idx_q;
  logic [2*W-1:0]      prod_q;
  logic [2*W-1:0]      mul_prod;

  // Full-width product of the currently selected coefficient pair.
  always_comb begin
    mul_prod = (2*W)'(a_q[idx_q]) * (2*W)'(b_q[idx_q]);
  end

  // Control FSM with registered handshake and stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      prod_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            idx_q    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state_q  <= StMul;
          end
        end
        StMul: begin
          prod_q  <= mul_prod;
          state_q <= StRed;
        end
        StRed: begin
          // Full-range reduction: latched operands may themselves be >= Q.
          out_data  <= W'(prod_q % QProd);
          out_idx   <= idx_q;
          out_last  <= (idx_q == LastIdx);
          out_valid <= 1'b1;
          state_q   <= StOut;
        end
        StOut: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (idx_q == LastIdx) begin
              in_ready <= 1'b1;
              busy     <= 1'b0;
              state_q  <= StIdle;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= StMul;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef NTT_PW_RANGE_CHECK_EN
  localparam logic [W-1:0] QCoef = W'(Q);

  logic range_bad;

  // Flags any incoming coefficient outside [0, Q).
  always_comb begin
    range_bad = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (a[i] >= QCoef || b[i] >= QCoef) begin
        range_bad = 1'b1;
      end
    end
  end

  // Sticky error, sampled only on the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (state_q == StIdle && in_valid && range_bad) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ntt_pointwise_mul.sv
// Self-checking bench for ntt_pointwise_mul: directed scenarios plus random
// vectors, each compared against a plain-arithmetic reference model.
module tb_ntt_pointwise_mul;

  localparam int unsigned N = 8;
  localparam int unsigned W = 8;
  localparam int unsigned Q = 17;

  typedef logic [N-1:0][W-1:0] vec_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  vec_t         a;
  vec_t         b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [2:0]   out_idx;
  logic         out_last;
  logic         busy;
  logic         err;

  int checks = 0;
  int errors = 0;
  bit err_exp = 1'b0;

  ntt_pointwise_mul #(.N(N), .W(W), .Q(Q)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic int unsigned ref_mul(input int unsigned x, input int unsigned y);
    return (x * y) % Q;
  endfunction

  function automatic bit range_exp(input vec_t va, input vec_t vb);
`ifdef NTT_PW_RANGE_CHECK_EN
    for (int i = 0; i < N; i++) begin
      if (int'(va[i]) >= int'(Q) || int'(vb[i]) >= int'(Q)) return 1'b1;
    end
`endif
    return 1'b0;
  endfunction

  function automatic vec_t rand_vec(input int unsigned maxv);
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = W'($urandom_range(0, maxv));
    return v;
  endfunction

  function automatic vec_t fill(input int unsigned val);
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = W'(val);
    return v;
  endfunction

  function automatic vec_t ramp();
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = W'(i + 1);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_out_idx"}, 32'(out_idx), 32'd0);
    check({tag, "_out_last"}, 32'(out_last), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // Present a vector pair and complete the accept handshake.
  task automatic send(input vec_t va, input vec_t vb);
    int cnt = 0;
    while (!in_ready && cnt < 100) begin
      step();
      cnt++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    err_exp  = err_exp | range_exp(va, vb);
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_in_ready", 32'(in_ready), 32'd0);
    check("accept_out_valid", 32'(out_valid), 32'd0);
    check("accept_err", 32'(err), 32'(err_exp));
    // Only the latched copies may matter from here on.
    a = rand_vec(255);
    b = rand_vec(255);
  endtask

  // Consume and check the product stream for one accepted vector pair.
  task automatic recv(input vec_t va, input vec_t vb, input int stall_idx, input int stall_len,
                      input bit rand_stall, input int pulse_idx, input int abort_idx);
    for (int i = 0; i < N; i++) begin
      int cnt = 0;
      int st;
      logic [31:0] exp_d;
      while (!out_valid && cnt < 10) begin
        step();
        cnt++;
      end
      check("latency", 32'(cnt), 32'd2);
      if (!out_valid) return;
      exp_d = 32'(ref_mul(int'(va[i]), int'(vb[i])));
      check("out_data", 32'(out_data), exp_d);
      check("out_idx", 32'(out_idx), 32'(i));
      check("out_last", 32'(out_last), 32'(i == N - 1));
      check("err", 32'(err), 32'(err_exp));
      if (i == abort_idx) begin
        rst = 1'b1;
        #1;
        check_reset("async_reset");
        #3;
        rst     = 1'b0;
        err_exp = 1'b0;
        step();
        check("post_reset_valid", 32'(out_valid), 32'd0);
        check("post_reset_ready", 32'(in_ready), 32'd1);
        return;
      end
      if (i == pulse_idx) begin
        in_valid = 1'b1;
        a        = rand_vec(255);
        b        = rand_vec(255);
        check("busy_in_ready", 32'(in_ready), 32'd0);
      end
      st = (i == stall_idx) ? stall_len : (rand_stall ? int'($urandom_range(0, 3)) : 0);
      if (st > 0) begin
        out_ready = 1'b0;
        for (int k = 0; k < st; k++) begin
          step();
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_data", 32'(out_data), exp_d);
          check("stall_idx", 32'(out_idx), 32'(i));
          check("stall_in_ready", 32'(in_ready), 32'd0);
        end
      end
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      check("handshake_drop", 32'(out_valid), 32'd0);
    end
    check("done_in_ready", 32'(in_ready), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t va;
    vec_t vb;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    step();
    check_reset("reset");
    rst = 1'b0;
    step();

    // Basic products with a ramp against all-ones.
    va = ramp();
    vb = fill(1);
    send(va, vb);
    recv(va, vb, -1, 0, 1'b0, -1, -1);

    // Reduction wraps: 16*16 = 256 -> 1, and 13*4 = 52 -> 1.
    va = fill(16);
    vb = fill(16);
    send(va, vb);
    recv(va, vb, -1, 0, 1'b0, -1, -1);
    va    = ramp();
    vb    = fill(1);
    va[0] = 8'd13;
    vb[0] = 8'd4;
    send(va, vb);
    recv(va, vb, -1, 0, 1'b0, -1, -1);

    // Backpressure: five stalled cycles at idx3.
    va = ramp();
    vb = fill(2);
    send(va, vb);
    recv(va, vb, 3, 5, 1'b0, -1, -1);

    // New vectors offered while busy are ignored; accepted later when idle.
    va = ramp();
    vb = fill(3);
    send(va, vb);
    recv(va, vb, 2, 2, 1'b0, 2, -1);
    va = fill(5);
    vb = ramp();
    send(va, vb);
    recv(va, vb, -1, 0, 1'b0, -1, -1);

    // Asynchronous reset while presenting idx5, then a fresh vector.
    va = fill(9);
    vb = fill(7);
    send(va, vb);
    recv(va, vb, -1, 0, 1'b0, -1, 5);
    va = ramp();
    vb = fill(1);
    send(va, vb);
    recv(va, vb, -1, 0, 1'b0, -1, -1);

    // Out-of-range coefficient: 20 mod 17 = 3 at idx2.
    va    = ramp();
    vb    = fill(1);
    va[2] = 8'd20;
    send(va, vb);
    recv(va, vb, -1, 0, 1'b0, -1, -1);

    // Random vectors with random backpressure.
    for (int r = 0; r < 6; r++) begin
      va = rand_vec((r < 3) ? Q - 1 : 255);
      vb = rand_vec((r < 3) ? Q - 1 : 255);
      send(va, vb);
      recv(va, vb, -1, 0, 1'b1, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
